// File: rtl/spmv_row_sequencer_if.sv
// Control and result handshake bundle for spmv_row_sequencer.
// The controller drives the master side; the sequencer is the slave.
interface spmv_row_sequencer_if;
  logic start;
  logic abort;
  logic out_ready;
  logic out_valid;
  int   out_data;
  int   out_row;
  logic busy;
  logic done;
  logic err_trunc;
  logic err_index;

  modport master (
    output start, abort, out_ready,
    input  out_valid, out_data, out_row, busy, done, err_trunc, err_index
  );

  modport slave (
    input  start, abort, out_ready,
    output out_valid, out_data, out_row, busy, done, err_trunc, err_index
  );
endinterface

// File: rtl/spmv_row_sequencer.sv
// Walks a CSR matrix one row at a time, accumulating val*vector[col] per row
// and handing each row result out over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | fetch row pointers, clear accumulator
// MAC   | one term per cycle into the accumulator
// EMIT  | hold row result until out_ready
// DONE  | one-cycle done pulse
module spmv_row_sequencer #(
  parameter int N_ROWS      = 4,
  parameter int M_COLS      = 4,
  parameter int NNZ         = 16,
  parameter int MAX_ROW_NNZ = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  spmv_row_sequencer_if.slave  bus,
  input  int                   val    [NNZ],
  input  int                   col    [NNZ],
  input  int                   rowPtr [N_ROWS+1],
  input  int                   vector [M_COLS]
);

  localparam int NW = (NNZ > 1) ? $clog2(NNZ) : 1;
  localparam int CW = (M_COLS > 1) ? $clog2(M_COLS) : 1;
  localparam int RW = $clog2(N_ROWS + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_MAC  = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state_q, state_d;
  int         row_q, row_d;
  int         acc_q, acc_d;
  int         i_q, i_d;
  int         hi_q, hi_d;
  int         cnt_q, cnt_d;
  logic       err_trunc_q, err_trunc_d;
  logic       err_index_q, err_index_d;

  int         row_nxt;
  int         ptr_lo;
  int         ptr_hi;
  int         hi_clamp;
  int         col_v;
  int         term;
  logic       term_ok;

  // Row pointer fetch and the single MAC term for the current index.
  always_comb begin
    row_nxt  = row_q + 1;
    ptr_lo   = rowPtr[row_q[RW-1:0]];
    ptr_hi   = rowPtr[row_nxt[RW-1:0]];
    hi_clamp = (ptr_hi > NNZ) ? NNZ : ptr_hi;
    col_v    = col[i_q[NW-1:0]];
    term_ok  = (i_q >= 0) && (i_q < NNZ) && (col_v >= 0) && (col_v < M_COLS);
    term     = term_ok ? val[i_q[NW-1:0]] * vector[col_v[CW-1:0]] : 0;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    acc_d       = acc_q;
    i_d         = i_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    err_trunc_d = err_trunc_q;
    err_index_d = err_index_q;

    // Abort beats everything, including a same-cycle EMIT handshake.
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            row_d       = 0;
            err_trunc_d = 1'b0;
            err_index_d = 1'b0;
            state_d     = S_LOAD;
          end
        end
        S_LOAD: begin
          acc_d = 0;
          i_d   = ptr_lo;
          hi_d  = hi_clamp;
          cnt_d = 0;
          if (ptr_hi > NNZ || ptr_hi < ptr_lo) begin
            err_index_d = 1'b1;
          end
          state_d = (hi_clamp <= ptr_lo) ? S_EMIT : S_MAC;
        end
        S_MAC: begin
          acc_d = acc_q + term;
          i_d   = i_q + 1;
          cnt_d = cnt_q + 1;
          if (!term_ok) begin
            err_index_d = 1'b1;
          end
          if (i_q + 1 >= hi_q) begin
            state_d = S_EMIT;
          end else if (cnt_q + 1 >= MAX_ROW_NNZ) begin
            err_trunc_d = 1'b1;
            state_d     = S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            if (row_q == N_ROWS - 1) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_nxt;
              state_d = S_LOAD;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      row_q       <= 0;
      acc_q       <= 0;
      i_q         <= 0;
      hi_q        <= 0;
      cnt_q       <= 0;
      err_trunc_q <= 1'b0;
      err_index_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      err_trunc_q <= err_trunc_d;
      err_index_q <= err_index_d;
    end
  end

  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_data  = acc_q;
  assign bus.out_row   = row_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err_trunc = err_trunc_q;
  assign bus.err_index = err_index_q;

endmodule

// File: tb/tb_spmv_row_sequencer.sv
// Scenario bench for spmv_row_sequencer: directed cases plus randomized
// passes checked against a loop-level CSR reference model.
module tb_spmv_row_sequencer;
  localparam int N  = 3;
  localparam int M  = 3;
  localparam int Z  = 4;
  localparam int MX = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spmv_row_sequencer_if bus ();

  int val    [Z];
  int col    [Z];
  int rowPtr [N+1];
  int vector [M];

  spmv_row_sequencer #(
    .N_ROWS(N), .M_COLS(M), .NNZ(Z), .MAX_ROW_NNZ(MX)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .val(val), .col(col), .rowPtr(rowPtr), .vector(vector)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int res_row [$];
  int res_data [$];
  bit pass_done;
  int done_gap;

  task automatic load_basic();
    val    = '{2, 3, 4, 5};
    col    = '{0, 2, 1, 2};
    rowPtr = '{0, 2, 2, 4};
    vector = '{1, 10, 100};
  endtask

  // Reference: plain CSR walk with clamp, skip and per-row term limit.
  task automatic model(output int exp_d [N], output bit e_tr, output bit e_ix);
    e_tr = 0;
    e_ix = 0;
    for (int r = 0; r < N; r++) begin
      int lo, nx, hi, acc, n, i;
      lo = rowPtr[r];
      nx = rowPtr[r+1];
      hi = (nx > Z) ? Z : nx;
      if (nx > Z || nx < lo) e_ix = 1;
      acc = 0;
      n = 0;
      i = lo;
      while (i < hi && n < MX) begin
        bit ok;
        ok = 0;
        if (i >= 0 && i < Z) begin
          if (col[i] >= 0 && col[i] < M) ok = 1;
        end
        if (ok) acc = acc + val[i] * vector[col[i]];
        else e_ix = 1;
        i++;
        n++;
      end
      if (i < hi) e_tr = 1;
      exp_d[r] = acc;
    end
  endtask

  task automatic run_pass(input bit rnd_ready, input int budget);
    int last_hs;
    res_row.delete();
    res_data.delete();
    pass_done = 0;
    done_gap = -1;
    last_hs = -100;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.done) begin
        pass_done = 1;
        done_gap = c - last_hs;
        break;
      end
      if (bus.out_valid && bus.out_ready) begin
        res_row.push_back(bus.out_row);
        res_data.push_back(bus.out_data);
        last_hs = c;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      if (!bus.busy) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0d expected 0", bus.out_valid); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d expected 0", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", bus.busy); end
    n_cmp++; if (bus.err_trunc !== 1'b0) begin n_fail++; $display("FAIL reset_err_trunc: got %0d expected 0", bus.err_trunc); end
    n_cmp++; if (bus.err_index !== 1'b0) begin n_fail++; $display("FAIL reset_err_index: got %0d expected 0", bus.err_index); end
    n_cmp++; if (bus.out_data !== 0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
    n_cmp++; if (bus.out_row !== 0) begin n_fail++; $display("FAIL reset_out_row: got %0d expected 0", bus.out_row); end
  endtask

  task automatic test_basic();
    int exp_r [3];
    int exp_d [3];
    exp_r = '{0, 1, 2};
    exp_d = '{302, 0, 540};
    load_basic();
    run_pass(1'b0, 60);
    n_cmp++; if (pass_done !== 1'b1) begin n_fail++; $display("FAIL basic_done_seen: got %0d expected 1", pass_done); end
    n_cmp++; if (res_row.size() !== 3) begin n_fail++; $display("FAIL basic_count: got %0d expected 3", res_row.size()); end
    for (int j = 0; j < 3 && j < res_row.size(); j++) begin
      n_cmp++; if (res_row[j] !== exp_r[j]) begin n_fail++; $display("FAIL basic_row%0d: got %0d expected %0d", j, res_row[j], exp_r[j]); end
      n_cmp++; if (res_data[j] !== exp_d[j]) begin n_fail++; $display("FAIL basic_data%0d: got %0d expected %0d", j, res_data[j], exp_d[j]); end
    end
    n_cmp++; if (done_gap !== 1) begin n_fail++; $display("FAIL basic_done_gap: got %0d expected 1", done_gap); end
    n_cmp++; if (bus.err_trunc !== 1'b0) begin n_fail++; $display("FAIL basic_err_trunc: got %0d expected 0", bus.err_trunc); end
    n_cmp++; if (bus.err_index !== 1'b0) begin n_fail++; $display("FAIL basic_err_index: got %0d expected 0", bus.err_index); end
  endtask

  task automatic test_timing();
    int c;
    bit ok;
    load_basic();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (!bus.out_valid && c < 20) begin @(negedge clk); c++; end
    n_cmp++; if (c !== 4) begin n_fail++; $display("FAIL timing_row0_latency: got %0d cycles expected 4", c); end
    @(negedge clk);
    c = 1;
    while (!bus.out_valid && c < 20) begin @(negedge clk); c++; end
    n_cmp++; if (c !== 2) begin n_fail++; $display("FAIL timing_row1_latency: got %0d cycles expected 2", c); end
    n_cmp++; if (bus.out_row !== 1) begin n_fail++; $display("FAIL timing_row1_index: got %0d expected 1", bus.out_row); end
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL timing_idle: got %0d expected 1", ok); end
  endtask

  task automatic test_backpressure();
    int c;
    bit ok;
    load_basic();
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (!bus.out_valid && c < 20) begin @(negedge clk); c++; end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d: got %0d expected 1", k, bus.out_valid); end
      n_cmp++; if (bus.out_data !== 302) begin n_fail++; $display("FAIL bp_data%0d: got %0d expected 302", k, bus.out_data); end
      n_cmp++; if (bus.out_row !== 0) begin n_fail++; $display("FAIL bp_row%0d: got %0d expected 0", k, bus.out_row); end
      bus.start = (k == 2);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_load_valid: got %0d expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_row !== 1) begin n_fail++; $display("FAIL bp_load_row: got %0d expected 1", bus.out_row); end
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_row1_valid: got %0d expected 1", bus.out_valid); end
    wait_idle(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %0d expected 1", ok); end
  endtask

  task automatic test_trunc();
    val    = '{1, 1, 1, 1};
    col    = '{0, 1, 2, 0};
    rowPtr = '{0, 3, 3, 4};
    vector = '{1, 1, 1};
    run_pass(1'b0, 60);
    n_cmp++; if (pass_done !== 1'b1) begin n_fail++; $display("FAIL trunc_done_seen: got %0d expected 1", pass_done); end
    n_cmp++; if (res_data.size() < 1 || res_data[0] !== 2) begin n_fail++; $display("FAIL trunc_row0_data: got %0d expected 2", res_data.size() > 0 ? res_data[0] : -1); end
    n_cmp++; if (bus.err_trunc !== 1'b1) begin n_fail++; $display("FAIL trunc_err_trunc: got %0d expected 1", bus.err_trunc); end
    n_cmp++; if (bus.err_index !== 1'b0) begin n_fail++; $display("FAIL trunc_err_index: got %0d expected 0", bus.err_index); end
  endtask

  task automatic test_bad_index();
    load_basic();
    col[1] = 7;
    run_pass(1'b0, 60);
    n_cmp++; if (pass_done !== 1'b1) begin n_fail++; $display("FAIL badidx_done_seen: got %0d expected 1", pass_done); end
    n_cmp++; if (res_data.size() !== 3) begin n_fail++; $display("FAIL badidx_count: got %0d expected 3", res_data.size()); end
    n_cmp++; if (res_data.size() < 1 || res_data[0] !== 2) begin n_fail++; $display("FAIL badidx_row0: got %0d expected 2", res_data.size() > 0 ? res_data[0] : -1); end
    n_cmp++; if (res_data.size() < 3 || res_data[2] !== 540) begin n_fail++; $display("FAIL badidx_row2: got %0d expected 540", res_data.size() > 2 ? res_data[2] : -1); end
    n_cmp++; if (bus.err_index !== 1'b1) begin n_fail++; $display("FAIL badidx_err_index: got %0d expected 1", bus.err_index); end
    n_cmp++; if (bus.err_trunc !== 1'b0) begin n_fail++; $display("FAIL badidx_err_trunc: got %0d expected 0", bus.err_trunc); end
  endtask

  task automatic test_abort();
    int c;
    bit saw_done;
    val    = '{2, 3, 4, 5};
    col    = '{7, 2, 1, 2};
    rowPtr = '{0, 1, 3, 4};
    vector = '{1, 10, 100};
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    while (!bus.out_valid && c < 20) begin @(negedge clk); c++; end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_row !== 1) begin n_fail++; $display("FAIL abort_in_row1: got %0d expected 1", bus.out_row); end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0d expected 0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid: got %0d expected 0", bus.out_valid); end
    n_cmp++; if (bus.err_index !== 1'b1) begin n_fail++; $display("FAIL abort_err_kept: got %0d expected 1", bus.err_index); end
    saw_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.done) saw_done = 1;
      @(negedge clk);
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", saw_done); end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_idle: got %0d expected 0", bus.busy); end
    n_cmp++; if (bus.err_index !== 1'b1) begin n_fail++; $display("FAIL start_abort_err_kept: got %0d expected 1", bus.err_index); end
  endtask

  task automatic test_reset_mid();
    bit saw;
    int exp_d [3];
    exp_d = '{302, 0, 540};
    val    = '{2, 3, 4, 5};
    col    = '{2, 7, 1, 2};
    rowPtr = '{0, 2, 2, 4};
    vector = '{1, 10, 100};
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 200) begin n_fail++; $display("FAIL rstmid_partial_acc: got %0d expected 200", bus.out_data); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 0) begin n_fail++; $display("FAIL rstmid_out_data: got %0d expected 0", bus.out_data); end
    n_cmp++; if (bus.out_row !== 0) begin n_fail++; $display("FAIL rstmid_out_row: got %0d expected 0", bus.out_row); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0d expected 0", bus.busy); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %0d expected 0", bus.out_valid); end
    rst = 1'b1;
    saw = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid || bus.done) saw = 1;
      @(negedge clk);
    end
    n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_emit: got %0d expected 0", saw); end
    load_basic();
    run_pass(1'b0, 60);
    n_cmp++; if (res_data.size() !== 3) begin n_fail++; $display("FAIL rstmid_rerun_count: got %0d expected 3", res_data.size()); end
    for (int j = 0; j < 3 && j < res_data.size(); j++) begin
      n_cmp++; if (res_data[j] !== exp_d[j]) begin n_fail++; $display("FAIL rstmid_rerun_data%0d: got %0d expected %0d", j, res_data[j], exp_d[j]); end
    end
  endtask

  task automatic test_random();
    int exp_d [N];
    bit e_tr, e_ix;
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < Z; i++) begin
        val[i] = int'($urandom);
        if ($urandom_range(0, 7) == 0)
          col[i] = ($urandom_range(0, 1) == 1) ? -1 : 3 + int'($urandom_range(0, 4));
        else
          col[i] = int'($urandom_range(0, 2));
      end
      for (int i = 0; i < M; i++) vector[i] = int'($urandom);
      rowPtr[0] = int'($urandom_range(0, 1));
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 7) == 0 && rowPtr[r] > 0) rowPtr[r+1] = rowPtr[r] - 1;
        else rowPtr[r+1] = rowPtr[r] + int'($urandom_range(0, 3));
      end
      model(exp_d, e_tr, e_ix);
      run_pass(1'b1, 300);
      n_cmp++; if (pass_done !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_done_seen: got %0d expected 1", p, pass_done); end
      n_cmp++; if (res_data.size() !== N) begin n_fail++; $display("FAIL rnd%0d_count: got %0d expected %0d", p, res_data.size(), N); end
      for (int j = 0; j < N && j < res_data.size(); j++) begin
        n_cmp++; if (res_row[j] !== j) begin n_fail++; $display("FAIL rnd%0d_row%0d: got %0d expected %0d", p, j, res_row[j], j); end
        n_cmp++; if (res_data[j] !== exp_d[j]) begin n_fail++; $display("FAIL rnd%0d_data%0d: got %0d expected %0d", p, j, res_data[j], exp_d[j]); end
      end
      n_cmp++; if (bus.err_trunc !== e_tr) begin n_fail++; $display("FAIL rnd%0d_err_trunc: got %0d expected %0d", p, bus.err_trunc, e_tr); end
      n_cmp++; if (bus.err_index !== e_ix) begin n_fail++; $display("FAIL rnd%0d_err_index: got %0d expected %0d", p, bus.err_index, e_ix); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b1;
    load_basic();
    rst = 1'b0;
    test_reset();
    rst = 1'b1;
    test_basic();
    test_timing();
    test_backpressure();
    test_trunc();
    test_bad_index();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/spmv_row_sequencer.md
SPMV_ROW_SEQUENCER -- requirements
Module: spmv_row_sequencer

Interface
REQ-001 Parameter N_ROWS, default 4: number of matrix rows (N_ROWS >= 1).
REQ-002 Parameter M_COLS, default 4: vector length.
REQ-003 Parameter NNZ, default 16: length of the val and col arrays.
REQ-004 Parameter MAX_ROW_NNZ, default 16: maximum terms accumulated per row.
REQ-005 Port clk  in  1: rising-edge clock.
REQ-006 Port rst  in  1: reset, synchronous, active-low.
REQ-007 Port start  in  1: begin a full-matrix pass; sampled only in IDLE.
REQ-008 Port abort  in  1: synchronous cancel of the current pass.
REQ-009 Port val[NNZ], col[NNZ], rowPtr[N_ROWS+1], vector[M_COLS]  in  int arrays: CSR matrix and dense vector, held stable from start until done or abort.
REQ-010 Port out_data  out  int: accumulated row result.
REQ-011 Port out_row  out  int: index of the row in out_data.
REQ-012 Port out_valid / out_ready  out / in  1: result handshake.
REQ-013 Port busy  out  1: high in every state except IDLE.
REQ-014 Port done  out  1: one-cycle pulse at end of a completed pass.
REQ-015 Port err_trunc, err_index  out  1: sticky error flags.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, MAC, EMIT, DONE.
REQ-017 IDLE: start=1 sets the row counter to 0, clears both error flags, and moves to LOAD.
REQ-018 LOAD (1 cycle): latch lo=rowPtr[r] and hi=min(rowPtr[r+1], NNZ), then clear the accumulator.
REQ-019 LOAD exit: if hi<=lo, go to EMIT with result 0; otherwise go to MAC with index i=lo.
REQ-020 If rowPtr[r+1] > NNZ, hi is clamped and err_index is set.
REQ-021 A descending pointer pair (rowPtr[r+1] < rowPtr[r]) is treated as an empty row and sets err_index.
REQ-022 MAC: exactly one term per cycle, acc += val[i]*vector[col[i]], using 32-bit two's-complement wraparound for both the product and the sum.
REQ-023 If col[i] < 0 or col[i] >= M_COLS, the term is skipped (adds 0) and err_index is set.
REQ-024 MAC exits to EMIT after term hi-1, or after MAX_ROW_NNZ terms, whichever comes first.
REQ-025 If a row is cut off by the MAX_ROW_NNZ limit, err_trunc is set.
REQ-026 EMIT: out_valid=1 with out_data=acc and out_row=r; both are held constant until out_ready=1.
REQ-027 An EMIT handshake with r<N_ROWS-1 increments r and goes to LOAD.
REQ-028 An EMIT handshake with r=N_ROWS-1 goes to DONE.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE.
REQ-030 Latency: a row with k accumulated terms asserts out_valid k+2 cycles after its LOAD entry edge; k=0 gives 2 cycles.
REQ-031 Throughput: each row occupies k+2 cycles when out_ready is held high.
REQ-032 start while busy is ignored.
REQ-033 abort in any non-IDLE state moves to IDLE on the next edge: no done, out_valid dropped, error flags retained.
REQ-034 abort has priority over an EMIT handshake in the same cycle; that row counts as not delivered.
REQ-035 Simultaneous start and abort in IDLE: abort wins, FSM stays IDLE.

Reset
REQ-036 rst=0 at a rising edge forces IDLE and sets out_valid, done, busy, err_trunc, err_index, out_data, out_row and the accumulator to 0.
REQ-037 rst=0 has priority over start, abort and the handshake, including mid-pass; no partial result is emitted afterwards.

Verification
REQ-038 Basic pass. Stimulus: N=3, M=3, NNZ=4, val={2,3,4,5}, col={0,2,1,2}, rowPtr={0,2,2,4}, vector={1,10,100}, out_ready=1, start pulse. Required response: outputs (row0, 302), (row1, 0), (row2, 540); done one cycle after the last handshake; no error flags.
REQ-039 Timing. Same data as REQ-038. Required response: row0 out_valid 4 cycles after the start edge; row1 out_valid 2 cycles after its LOAD entry.
REQ-040 Backpressure. Same data, out_ready=0 for 5 cycles during row0 EMIT. Required response: out_data=302 and out_row=0 held stable; row1 LOAD begins only after the handshake.
REQ-041 Truncation. MAX_ROW_NNZ=2, row of 3 terms, all val=1 and vector=1. Required response: out_data=2, err_trunc=1.
REQ-042 Bad index. col[1]=7 with M=3. Required response: term skipped, err_index=1; pass completes with done.
REQ-043 Abort and reset. abort during row1 MAC: IDLE next cycle, no done. Separately, rst=0 mid-MAC: all outputs 0. Required response: a new start then reproduces the REQ-038 results.
